// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone two-master arbiter: bus widths,
// arbiter state encoding and the state-to-grant mapping.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  // One-hot owner vector presented on grant_o; IDLE reports no owner.
  function automatic logic [1:0] grant_of(arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == OWN0) g = 2'b01;
    if (st == OWN1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts owned strobe cycles without ACK, flags expiry for
// one cycle and latches a sticky timeout indication until reset.
module wb_arb_watchdog
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic expire,
  output logic timeout_flag
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // A same-cycle ACK beats the expiry; TIMEOUT of zero never expires.
  assign expire = (TIMEOUT != 0) && active && !ack && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || ack) begin
      cnt <= '0;
    end else if (stb && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (expire) begin
      timeout_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone classic arbiter sharing one slave between the CPU
// instruction and data buses, with cycle locking and a stall watchdog.
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int FAIR    = 1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic                m0_we_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic                m1_we_i,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_t state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic       sel_m1;
  logic       owned;
  logic       own_cyc;
  logic       own_stb;
  logic       expire;

  assign sel_m1  = (state == OWN1);
  assign owned   = (state != IDLE);
  assign own_cyc = owned && (sel_m1 ? m1_cyc_i : m0_cyc_i);
  assign own_stb = owned && (sel_m1 ? m1_stb_i : m0_stb_i);

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Owners always return through IDLE, leaving one dead cycle so the
  // slave's toggling ACK clears before the other master is granted.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if ((FAIR != 0) && !last_owner) begin
            state_nxt      = OWN1;
            last_owner_nxt = 1'b1;
          end else begin
            state_nxt      = OWN0;
            last_owner_nxt = 1'b0;
          end
        end else if (m0_cyc_i) begin
          state_nxt      = OWN0;
          last_owner_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = OWN1;
          last_owner_nxt = 1'b1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i || expire) state_nxt = IDLE;
      end
      OWN1: begin
        if (!m1_cyc_i || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_watchdog (
    .clk         (wb_clk_i),
    .rst_n       (wb_rstn_i),
    .active      (owned),
    .stb         (own_stb),
    .ack         (s_ack_i),
    .expire      (expire),
    .timeout_flag(timeout_o)
  );

  // Address/data path follows the owner; with no owner it shows m0.
  assign s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
  assign s_cyc_o = own_cyc && !expire;
  assign s_stb_o = own_stb && !expire;

  assign m0_ack_o = (state == OWN0) && s_ack_i;
  assign m1_ack_o = (state == OWN1) && s_ack_i;
  assign m0_err_o = (state == OWN0) && expire;
  assign m1_err_o = (state == OWN1) && expire;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign grant_o = grant_of(state);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the
// same master stimulus, each with its own RAM-like slave and reference model.
module tb_wb_bus_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        force_nack;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];

  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic        a0 [2];
  logic        a1 [2];
  logic        e0 [2];
  logic        e1 [2];
  logic [31:0] s_adr  [2];
  logic [31:0] s_wdat [2];
  logic [3:0]  s_sel  [2];
  logic        s_we   [2];
  logic        s_cyc  [2];
  logic        s_stb  [2];
  logic [31:0] s_rdat [2];
  logic        s_ack  [2];
  logic [1:0]  grant  [2];
  logic        tmo    [2];

  logic [31:0] mem [2][256];

  int errors;
  int checks;

  // Instance 0 is round-robin, instance 1 gives m0 fixed priority.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_bus_arbiter #(
      .FAIR   ((g == 0) ? 1 : 0),
      .TIMEOUT(TO),
      .CNT_W  (8)
    ) dut (
      .wb_clk_i (clk),
      .wb_rstn_i(rst_n),
      .m0_adr_i (m_adr[0]),
      .m0_dat_i (m_dat[0]),
      .m0_sel_i (m_sel[0]),
      .m0_we_i  (m_we[0]),
      .m0_cyc_i (m_cyc[0]),
      .m0_stb_i (m_stb[0]),
      .m0_dat_o (d0[g]),
      .m0_ack_o (a0[g]),
      .m0_err_o (e0[g]),
      .m1_adr_i (m_adr[1]),
      .m1_dat_i (m_dat[1]),
      .m1_sel_i (m_sel[1]),
      .m1_we_i  (m_we[1]),
      .m1_cyc_i (m_cyc[1]),
      .m1_stb_i (m_stb[1]),
      .m1_dat_o (d1[g]),
      .m1_ack_o (a1[g]),
      .m1_err_o (e1[g]),
      .s_adr_o  (s_adr[g]),
      .s_dat_o  (s_wdat[g]),
      .s_sel_o  (s_sel[g]),
      .s_we_o   (s_we[g]),
      .s_cyc_o  (s_cyc[g]),
      .s_stb_o  (s_stb[g]),
      .s_dat_i  (s_rdat[g]),
      .s_ack_i  (s_ack[g]),
      .grant_o  (grant[g]),
      .timeout_o(tmo[g])
    );
  end

  // RAM-like slaves with a toggling registered ACK, one per arbiter.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        s_ack[k]  <= 1'b0;
        s_rdat[k] <= 32'h0;
        for (int i = 0; i < 256; i++) mem[k][i] <= 32'hA5A5_0000 | i;
        mem[k][4] <= 32'hDEADBEEF;
      end else begin
        s_ack[k] <= s_cyc[k] & s_stb[k] & ~s_ack[k] & ~force_nack;
        if (s_cyc[k] && s_stb[k] && !s_ack[k]) begin
          if (s_we[k]) mem[k][s_adr[k][9:2]] <= s_wdat[k];
          s_rdat[k] <= mem[k][s_adr[k][9:2]];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_we[m]  = we;
    m_adr[m] = adr;
    m_dat[m] = dat;
    m_sel[m] = 4'hF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: owner is -1 (none), 0 or 1; wcnt counts unanswered strobes.
  int       owner    [2];
  int       last_own [2];
  int       wcnt     [2];
  bit       tflag    [2];
  int       src;
  bit       ocyc, ostb, expire;
  logic [8:0] got_stat, exp_stat;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      got_stat = {grant[k], s_cyc[k], s_stb[k], a0[k], a1[k], e0[k], e1[k], tmo[k]};
      if (!rst_n) begin
        owner[k]    = -1;
        last_own[k] = 1;
        wcnt[k]     = 0;
        tflag[k]    = 1'b0;
        checkOutput($sformatf("reset_status[%0d]", k), got_stat, 9'b0);
      end else begin
        src    = (owner[k] == 1) ? 1 : 0;
        ocyc   = (owner[k] >= 0) && m_cyc[src];
        ostb   = (owner[k] >= 0) && m_stb[src];
        expire = (owner[k] >= 0) && (wcnt[k] == TO) && !s_ack[k];
        exp_stat = {owner[k] == 1, owner[k] == 0, ocyc && !expire, ostb && !expire,
                    owner[k] == 0 && s_ack[k], owner[k] == 1 && s_ack[k],
                    owner[k] == 0 && expire, owner[k] == 1 && expire, tflag[k]};
        checkOutput($sformatf("status[%0d]", k), got_stat, exp_stat);
        checkOutput($sformatf("s_adr_dat[%0d]", k), {s_adr[k], s_wdat[k]}, {m_adr[src], m_dat[src]});
        checkOutput($sformatf("s_sel_we[%0d]", k), {s_sel[k], s_we[k]}, {m_sel[src], m_we[src]});
        checkOutput($sformatf("m_rdat[%0d]", k), {d0[k], d1[k]}, {s_rdat[k], s_rdat[k]});
        if (expire) tflag[k] = 1'b1;
        if (owner[k] < 0) begin
          wcnt[k] = 0;
          if (m_cyc[0] && m_cyc[1]) owner[k] = (k == 0) ? 1 - last_own[k] : 0;
          else if (m_cyc[0])        owner[k] = 0;
          else if (m_cyc[1])        owner[k] = 1;
          if (owner[k] >= 0) last_own[k] = owner[k];
        end else if (!ocyc || expire) begin
          owner[k] = -1;
          wcnt[k]  = 0;
        end else if (s_ack[k]) begin
          wcnt[k] = 0;
        end else if (ostb) begin
          wcnt[k] = wcnt[k] + 1;
        end
      end
    end
  end

  int         nseq, gap, m1_hits;
  logic [1:0] seq [3];
  logic [1:0] prev, gcur;
  bit         ack0, ack1, got_ack;
  int         owned_cnt [2];
  int         err_at    [2];
  bit         prev_err  [2];
  bit         cyc_r;

  initial begin
    errors     = 0;
    checks     = 0;
    force_nack = 1'b0;
    rst_n      = 1'b0;
    for (int m = 0; m < 2; m++) applyStimulus(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkOutput("idle_grant", grant[k], 2'b00);
        checkOutput("idle_cyc", s_cyc[k], 1'b0);
      end
    end

    // Single m0 read of 0x10
    tick();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checkOutput("rd_cyc_n", s_cyc[0], 1'b0);
    @(negedge clk);
    checkOutput("rd_cyc_n1", s_cyc[0], 1'b1);
    checkOutput("rd_ack_n1", a0[0], 1'b0);
    @(negedge clk);
    checkOutput("rd_ack", a0[0], 1'b1);
    checkOutput("rd_data", d0[0], 32'hDEADBEEF);
    checkOutput("rd_m1_ack", a1[0], 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Round-robin alternation with single-beat owners
    resetDut();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    nseq = 0;
    gap  = 0;
    prev = 2'b00;
    for (int c = 0; c < 40 && nseq < 3; c++) begin
      @(negedge clk);
      gcur = grant[0];
      ack0 = a0[0];
      ack1 = a1[0];
      if (gcur != 2'b00 && gcur != prev) begin
        seq[nseq] = gcur;
        if (nseq > 0) checkOutput("rr_idle_gap", gap, 1);
        nseq++;
      end
      gap  = (gcur == 2'b00) ? gap + 1 : 0;
      prev = gcur;
      tick();
      applyStimulus(0, !ack0, !ack0, 1'b0, 32'h20, 32'h0);
      applyStimulus(1, !ack1, !ack1, 1'b0, 32'h24, 32'h0);
    end
    checkOutput("rr_rounds", nseq, 3);
    checkOutput("rr_seq0", seq[0], 2'b01);
    checkOutput("rr_seq1", seq[1], 2'b10);
    checkOutput("rr_seq2", seq[2], 2'b01);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fixed priority: m0 holds, m1 write waits, then read back
    resetDut();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h12345678);
    m1_hits = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (grant[1] == 2'b10) m1_hits++;
    end
    checkOutput("fp_m1_starved", m1_hits, 0);
    checkOutput("fp_m0_owner", grant[1], 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(negedge clk);
      got_ack = a1[1];
    end
    checkOutput("fp_m1_wr_ack", got_ack, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(negedge clk);
      got_ack = a1[1];
    end
    checkOutput("fp_m1_rd_ack", got_ack, 1'b1);
    checkOutput("fp_readback", d1[1], 32'h12345678);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Watchdog expiry with the slave never acknowledging
    resetDut();
    force_nack = 1'b1;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    for (int k = 0; k < 2; k++) begin
      owned_cnt[k] = 0;
      err_at[k]    = 0;
      prev_err[k]  = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (prev_err[k]) checkOutput("wd_idle_after", grant[k], 2'b00);
        prev_err[k] = e1[k];
        if (grant[k] == 2'b10) owned_cnt[k]++;
        if (e1[k] && err_at[k] == 0) begin
          err_at[k] = owned_cnt[k];
          checkOutput("wd_cyc_drop", s_cyc[k], 1'b0);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput("wd_err_cycle", err_at[k], TO + 1);
      checkOutput("wd_sticky", tmo[k], 1'b1);
    end
    tick();
    force_nack = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset asserted in the middle of an m0 beat
    tick();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("rst_pre_cyc", s_cyc[0], 1'b1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_async_cyc", s_cyc[k], 1'b0);
      checkOutput("rst_async_grant", grant[k], 2'b00);
      checkOutput("rst_async_resp", {a0[k], a1[k], e0[k], e1[k]}, 4'b0);
    end
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput("rst_rel_idle", grant[k], 2'b00);
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput("rst_tie_m0", grant[k], 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomised traffic, slave stalls and occasional resets
    for (int c = 0; c < 1500; c++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) force_nack = !force_nack;
      for (int m = 0; m < 2; m++) begin
        cyc_r = m_cyc[m];
        if ($urandom_range(0, 7) == 0) cyc_r = !cyc_r;
        applyStimulus(m, cyc_r, cyc_r && ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), $urandom & 32'h0000_03FC, $urandom);
      end
    end
    tick();
    rst_n      = 1'b1;
    force_nack = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
